// File: rtl/vid_native_to_axis.sv
// Native video (data/vsync/active) to AXI4-Stream video bridge.
// One-pixel hold stage gives end-of-line lookahead; a FIFO with a registered head feeds the AXIS port.
module vid_native_to_axis #(
    parameter int DATA_WID     = 24,
    parameter int DEST_WID     = 2,
    parameter int DEST         = 0,
    parameter int DEPTH        = 16,
    parameter int AFULL_MARGIN = 4,
    parameter int VSYNC_POL    = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WID-1:0]     vid_data,
    input  logic                    vid_vsync,
    input  logic                    vid_active,
    output logic                    vid_vtg_ce,
    output logic [DATA_WID-1:0]     m_axis_tdata,
    output logic [DEST_WID-1:0]     m_axis_tdest,
    output logic [DATA_WID/8-1:0]   m_axis_tkeep,
    output logic                    m_axis_tuser,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    overflow,
    input  logic                    ovf_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = DATA_WID + 2;

    typedef enum logic [1:0] {WAIT_SOF, RUN, RESYNC} state_t;
    state_t state, state_nxt;

    logic                vs_act, vs_q, vs_edge, sof_pend, cap_sof;
    logic                hold_vld, hold_sof, hold_ld;
    logic [DATA_WID-1:0] hold_data;
    logic [EW-1:0]       mem [DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [LW-1:0]       unloaded;
    logic                full, pop, wr_try, push, drop, head_ld;

    assign m_axis_tkeep = '1;
    assign m_axis_tdest = DEST_WID'(DEST);

    assign vs_act  = (VSYNC_POL != 0) ? vid_vsync : ~vid_vsync;
    assign vs_edge = vs_act & ~vs_q;
    // A pixel coinciding with the vsync edge is not tagged; sof_pend is only armed by it.
    assign cap_sof = vid_active & sof_pend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_q     <= 1'b0;
            sof_pend <= 1'b0;
        end else begin
            vs_q     <= vs_act;
            sof_pend <= vs_edge | (sof_pend & ~cap_sof);
        end
    end

    assign full     = (level == LW'(DEPTH));
    assign pop      = m_axis_tvalid & m_axis_tready;
    assign wr_try   = (state == RUN) & hold_vld;
    assign push     = wr_try & (~full | pop);
    assign drop     = wr_try & full & ~pop;
    // Entries stored but not yet copied into the output head register.
    assign unloaded = level - LW'(m_axis_tvalid);
    assign head_ld  = (~m_axis_tvalid | pop) & (unloaded != '0);

    always_comb begin
        state_nxt = state;
        hold_ld   = 1'b0;
        case (state)
            RUN: begin
                if (drop) state_nxt = RESYNC;
                else      hold_ld   = vid_active;
            end
            default: begin
                hold_ld = cap_sof;
                if (cap_sof) state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= WAIT_SOF;
            hold_vld  <= 1'b0;
            hold_sof  <= 1'b0;
            hold_data <= '0;
        end else begin
            state    <= state_nxt;
            hold_vld <= hold_ld;
            if (hold_ld) begin
                hold_sof  <= cap_sof;
                hold_data <= vid_data;
            end
        end
    end

    // The held pixel is the last of its line when active has already fallen.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {hold_sof, ~vid_active, hold_data};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level         <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
            overflow      <= 1'b0;
            vid_vtg_ce    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            level <= level + LW'(push) - LW'(pop);
            if (head_ld) begin
                {m_axis_tuser, m_axis_tlast, m_axis_tdata} <= mem[rd_ptr];
                rd_ptr        <= rd_ptr + AW'(1);
                m_axis_tvalid <= 1'b1;
            end else if (pop) begin
                m_axis_tvalid <= 1'b0;
            end
            overflow   <= drop | (overflow & ~ovf_clr);
            vid_vtg_ce <= (level < LW'(DEPTH - AFULL_MARGIN));
        end
    end
endmodule

// File: tb/tb_vid_native_to_axis.sv
// Directed bench for vid_native_to_axis: framing, latency, back-pressure, overflow, reset.
module tb_vid_native_to_axis;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] vid_data = '0;
    logic        vid_vsync = 1'b0;
    logic        vid_active = 1'b0;
    logic        vid_vtg_ce;
    logic [23:0] m_axis_tdata;
    logic [1:0]  m_axis_tdest;
    logic [2:0]  m_axis_tkeep;
    logic        m_axis_tuser, m_axis_tlast, m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic [4:0]  level;
    logic        overflow;
    logic        ovf_clr = 1'b0;

    int n_chk = 0;
    int n_fail = 0;
    logic [25:0] got [$];

    vid_native_to_axis dut (
        .clk(clk), .rst(rst), .vid_data(vid_data), .vid_vsync(vid_vsync),
        .vid_active(vid_active), .vid_vtg_ce(vid_vtg_ce),
        .m_axis_tdata(m_axis_tdata), .m_axis_tdest(m_axis_tdest),
        .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
        .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .level(level), .overflow(overflow),
        .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    // Record every accepted beat as {tuser, tlast, tdata}.
    always @(negedge clk)
        if (!rst && m_axis_tvalid && m_axis_tready)
            got.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic exp_beat(input string tag, input logic u, input logic l, input logic [23:0] d);
        logic [25:0] g;
        g = (got.size() > 0) ? got.pop_front() : 26'bx;
        n_chk++;
        assert (g === {u, l, d}) else begin
            n_fail++;
            $error("FAIL %s: observed beat %0h expected %0h", tag, g, {u, l, d});
        end
    endtask

    task automatic vsync_pulse();
        vid_vsync = 1'b1;
        tick();
        vid_vsync = 1'b0;
        tick();
    endtask

    task automatic line(input logic [23:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            vid_data   = base + 24'(i);
            vid_active = 1'b1;
            tick();
        end
        vid_active = 1'b0;
    endtask

    initial begin
        // Reset values
        #2;
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_tuser", m_axis_tuser, 0);
        chk("rst_tlast", m_axis_tlast, 0);
        chk("rst_level", level, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_ce", vid_vtg_ce, 0);
        chk("rst_tkeep", m_axis_tkeep, 3'b111);
        chk("rst_tdest", m_axis_tdest, 0);
        tick(2);
        rst = 1'b0;
        tick();
        chk("ce_after_rst", vid_vtg_ce, 1);

        // Pixels before any vsync edge are discarded
        m_axis_tready = 1'b1;
        line(24'h0000a1, 4);
        tick(5);
        chk("pre_sof_level", level, 0);
        chk("pre_sof_tvalid", m_axis_tvalid, 0);
        chk("pre_sof_q", got.size(), 0);

        // Frame 2x4, latency
        vsync_pulse();
        vid_active = 1'b1; vid_data = 24'h1;
        tick();
        chk("lat_e0_tvalid", m_axis_tvalid, 0);
        vid_data = 24'h2;
        tick();
        chk("lat_e1_level", level, 1);
        chk("lat_e1_tvalid", m_axis_tvalid, 0);
        vid_data = 24'h3;
        tick();
        chk("lat_e2_tvalid", m_axis_tvalid, 1);
        chk("lat_e2_tdata", m_axis_tdata, 24'h1);
        chk("lat_e2_tuser", m_axis_tuser, 1);
        vid_data = 24'h4;
        tick();
        vid_active = 1'b0;
        tick(2);
        line(24'h5, 4);
        tick(6);
        exp_beat("f1_b1", 1, 0, 24'h1);
        exp_beat("f1_b2", 0, 0, 24'h2);
        exp_beat("f1_b3", 0, 0, 24'h3);
        exp_beat("f1_b4", 0, 1, 24'h4);
        exp_beat("f1_b5", 0, 0, 24'h5);
        exp_beat("f1_b6", 0, 0, 24'h6);
        exp_beat("f1_b7", 0, 0, 24'h7);
        exp_beat("f1_b8", 0, 1, 24'h8);
        chk("f1_q_empty", got.size(), 0);
        chk("f1_level", level, 0);

        // Back-pressure: vtg_ce falls the cycle after level hits 12
        m_axis_tready = 1'b0;
        vsync_pulse();
        for (int i = 1; i <= 20; i++) begin
            vid_data   = 24'h100 + 24'(i);
            vid_active = 1'b1;
            tick();
            if (i == 13) begin
                chk("bp_level12", level, 12);
                chk("bp_ce_hi", vid_vtg_ce, 1);
                chk("bp_stall_tdata", m_axis_tdata, 24'h101);
            end
            if (i == 14) begin
                chk("bp_level13", level, 13);
                chk("bp_ce_lo", vid_vtg_ce, 0);
                chk("bp_stall_tvalid", m_axis_tvalid, 1);
                chk("bp_stall_tdata2", m_axis_tdata, 24'h101);
                chk("bp_stall_tuser", m_axis_tuser, 1);
                m_axis_tready = 1'b1;
            end
        end
        vid_active = 1'b0;
        tick(30);
        for (int i = 1; i <= 20; i++)
            exp_beat("bp_beat", i == 1, i == 20, 24'h100 + 24'(i));
        chk("bp_q_empty", got.size(), 0);
        chk("bp_ce_back", vid_vtg_ce, 1);

        // Overflow: 20 pixels into 16 entries, output stalled
        m_axis_tready = 1'b0;
        vsync_pulse();
        line(24'h201, 20);
        tick(3);
        chk("ovf_level", level, 16);
        chk("ovf_flag", overflow, 1);
        chk("ovf_ce", vid_vtg_ce, 0);
        line(24'h221, 4);
        tick(2);
        chk("ovf_resync_level", level, 16);
        m_axis_tready = 1'b1;
        tick(20);
        chk("ovf_drained", level, 0);
        chk("ovf_drained_tvalid", m_axis_tvalid, 0);
        for (int i = 0; i < 16; i++)
            exp_beat("ovf_beat", i == 0, 0, 24'h201 + 24'(i));
        chk("ovf_q_empty", got.size(), 0);
        chk("ovf_sticky", overflow, 1);
        vsync_pulse();
        line(24'h231, 3);
        tick(6);
        exp_beat("ovf_rs_b1", 1, 0, 24'h231);
        exp_beat("ovf_rs_b2", 0, 0, 24'h232);
        exp_beat("ovf_rs_b3", 0, 1, 24'h233);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_clr", overflow, 0);

        // Push and pop at full
        m_axis_tready = 1'b0;
        vsync_pulse();
        for (int i = 0; i < 17; i++) begin
            vid_data   = 24'h401 + 24'(i);
            vid_active = 1'b1;
            tick();
        end
        chk("pp_full", level, 16);
        vid_active    = 1'b0;
        m_axis_tready = 1'b1;
        tick();
        chk("pp_level", level, 16);
        chk("pp_no_ovf", overflow, 0);
        tick(20);
        for (int i = 0; i < 17; i++)
            exp_beat("pp_beat", i == 0, i == 16, 24'h401 + 24'(i));
        chk("pp_q_empty", got.size(), 0);

        // Reset mid-line
        m_axis_tready = 1'b0;
        vsync_pulse();
        for (int i = 0; i < 6; i++) begin
            vid_data   = 24'h501 + 24'(i);
            vid_active = 1'b1;
            tick();
        end
        rst = 1'b1;
        #1;
        chk("mrst_tvalid", m_axis_tvalid, 0);
        chk("mrst_tdata", m_axis_tdata, 0);
        chk("mrst_level", level, 0);
        chk("mrst_ce", vid_vtg_ce, 0);
        vid_data = 24'h507;
        tick();
        vid_data = 24'h508;
        tick();
        rst = 1'b0;
        vid_data = 24'h509;
        tick();
        vid_data = 24'h50a;
        tick();
        vid_active    = 1'b0;
        m_axis_tready = 1'b1;
        tick(6);
        chk("mrst_no_out", m_axis_tvalid, 0);
        chk("mrst_no_lvl", level, 0);
        chk("mrst_q_empty", got.size(), 0);
        vsync_pulse();
        line(24'h511, 2);
        tick(6);
        exp_beat("mrst_b1", 1, 0, 24'h511);
        exp_beat("mrst_b2", 0, 1, 24'h512);
        chk("mrst_q_end", got.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
